// File: rtl/ir_tx_cmd_queue_pkg.sv
// Shared widths, FSM encoding and queued-frame layout for the NEC IR command queue.
// IR_TX_REPEAT_EN adds a per-entry repeat count to the frame.
package ir_tx_pkg;

  localparam int unsigned NEC_ADDR_W = 16;
  localparam int unsigned NEC_CMD_W  = 8;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_REQ  = 2'd1;
  localparam state_t S_BUSY = 2'd2;
  localparam state_t S_GAP  = 2'd3;

  typedef struct packed {
    logic [NEC_ADDR_W-1:0] addr;
    logic [NEC_CMD_W-1:0]  cmd;
`ifdef IR_TX_REPEAT_EN
    logic [3:0]            rpt;
`endif
  } frame_t;

endpackage

// File: rtl/ir_tx_cmd_queue_if.sv
// Host-write and transmitter-drive signal bundle for ir_tx_cmd_queue.
// IR_TX_REPEAT_EN adds the wr_repeat field.
interface ir_tx_cmd_queue_if
  import ir_tx_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) ();
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic                  wr_en;
  logic [NEC_ADDR_W-1:0] wr_addr;
  logic [NEC_CMD_W-1:0]  wr_cmd;
  logic                  wr_full;
  logic                  wr_ovf;
  logic [LW-1:0]         fifo_level;
  logic [NEC_ADDR_W-1:0] tx_addr;
  logic [NEC_CMD_W-1:0]  tx_cmd;
  logic                  tx_send;
  logic                  tx_busy;
`ifdef IR_TX_REPEAT_EN
  logic [3:0]            wr_repeat;
`endif

  modport master (
    output wr_en, wr_addr, wr_cmd, tx_busy,
    input  wr_full, wr_ovf, fifo_level, tx_addr, tx_cmd, tx_send
`ifdef IR_TX_REPEAT_EN
    , output wr_repeat
`endif
  );

  modport slave (
    input  wr_en, wr_addr, wr_cmd, tx_busy,
    output wr_full, wr_ovf, fifo_level, tx_addr, tx_cmd, tx_send
`ifdef IR_TX_REPEAT_EN
    , input wr_repeat
`endif
  );

endinterface

// File: rtl/ir_tx_cmd_queue_fifo.sv
// Synchronous frame FIFO with occupancy count and dropped-push pulse.
// Head entry is presented combinationally on rd_data.
module ir_tx_fifo
  import ir_tx_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  frame_t        wr_data,
  input  logic          rd_en,
  output frame_t        rd_data,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic [LW-1:0] count
);

  frame_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Full is judged on the registered count, so a pop in the same cycle cannot admit a push.
  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      ovf <= wr_en && full;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ir_tx_cmd_queue.sv
// Queues {addr, cmd} frames and feeds them one at a time to the NEC transmitter.
// IR_TX_REPEAT_EN: each entry is sent wr_repeat+1 times before the next pop.
module ir_tx_cmd_queue
  import ir_tx_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned ACK_TIMEOUT = 1000,
  parameter int unsigned GAP_CYCLES  = 0
) (
  input  logic                clk,
  input  logic                rst,
  ir_tx_cmd_queue_if.slave    bus,
  output logic                err_timeout,
  output logic [15:0]         frames_sent,
  output logic                q_idle
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  state_t                state;
  logic [31:0]           timer;
  logic [NEC_ADDR_W-1:0] tx_addr_q;
  logic [NEC_CMD_W-1:0]  tx_cmd_q;
  logic                  tx_send_q;
  frame_t                wr_frame;
  frame_t                head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_ovf;
  logic [LW-1:0]         level;
  logic                  pop;
  logic                  more_reps;

  always_comb begin
    wr_frame      = '0;
    wr_frame.addr = bus.wr_addr;
    wr_frame.cmd  = bus.wr_cmd;
`ifdef IR_TX_REPEAT_EN
    wr_frame.rpt  = bus.wr_repeat;
`endif
  end

  assign pop = (state == S_IDLE) && !fifo_empty;

  ir_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.wr_en),
    .wr_data (wr_frame),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .ovf     (fifo_ovf),
    .count   (level)
  );

`ifdef IR_TX_REPEAT_EN
  logic [3:0] rep_left;
  assign more_reps = (rep_left != '0);
`else
  assign more_reps = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      timer       <= '0;
      tx_addr_q   <= '0;
      tx_cmd_q    <= '0;
      tx_send_q   <= 1'b0;
      err_timeout <= 1'b0;
      frames_sent <= '0;
`ifdef IR_TX_REPEAT_EN
      rep_left    <= '0;
`endif
    end else begin
      err_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          // Launch even if busy is already high; S_REQ then consumes that busy period.
          if (!fifo_empty) begin
            tx_addr_q <= head.addr;
            tx_cmd_q  <= head.cmd;
            tx_send_q <= 1'b1;
            timer     <= '0;
            state     <= S_REQ;
`ifdef IR_TX_REPEAT_EN
            rep_left  <= head.rpt;
`endif
          end
        end
        S_REQ: begin
          if (bus.tx_busy) begin
            tx_send_q <= 1'b0;
            state     <= S_BUSY;
          end else if (timer == ACK_TIMEOUT - 1) begin
            tx_send_q   <= 1'b0;
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        S_BUSY: begin
          if (!bus.tx_busy) begin
            frames_sent <= frames_sent + 16'd1;
            timer       <= '0;
            if (GAP_CYCLES != 0) begin
              state <= S_GAP;
            end else if (more_reps) begin
              tx_send_q <= 1'b1;
              state     <= S_REQ;
`ifdef IR_TX_REPEAT_EN
              rep_left  <= rep_left - 4'd1;
`endif
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (timer == GAP_CYCLES - 1) begin
            timer <= '0;
            if (more_reps) begin
              tx_send_q <= 1'b1;
              state     <= S_REQ;
`ifdef IR_TX_REPEAT_EN
              rep_left  <= rep_left - 4'd1;
`endif
            end else begin
              state <= S_IDLE;
            end
          end else begin
            timer <= timer + 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.tx_addr    = tx_addr_q;
  assign bus.tx_cmd     = tx_cmd_q;
  assign bus.tx_send    = tx_send_q;
  assign bus.wr_full    = fifo_full;
  assign bus.wr_ovf     = fifo_ovf;
  assign bus.fifo_level = level;
  assign q_idle         = (state == S_IDLE) && fifo_empty;

endmodule

// File: tb/tb_ir_tx_cmd_queue.sv
// Directed bench for ir_tx_cmd_queue: default instance plus a GAP_CYCLES=50 instance.
module tb_ir_tx_cmd_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ir_tx_cmd_queue_if #(.DEPTH(8)) b0 ();
  ir_tx_cmd_queue_if #(.DEPTH(8)) b1 ();

  logic        err0, err1, q0, q1;
  logic [15:0] fs0, fs1;

  ir_tx_cmd_queue #(.DEPTH(8), .ACK_TIMEOUT(1000), .GAP_CYCLES(0)) u_dut (
    .clk(clk), .rst(rst), .bus(b0.slave),
    .err_timeout(err0), .frames_sent(fs0), .q_idle(q0)
  );

  ir_tx_cmd_queue #(.DEPTH(8), .ACK_TIMEOUT(1000), .GAP_CYCLES(50)) u_gap (
    .clk(clk), .rst(rst), .bus(b1.slave),
    .err_timeout(err1), .frames_sent(fs1), .q_idle(q1)
  );

  int total   = 0;
  int bad     = 0;
  int ovf_cnt = 0;

  always @(negedge clk) if (b0.wr_ovf) ovf_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push0(input logic [15:0] a, input logic [7:0] c);
    b0.wr_en   = 1'b1;
    b0.wr_addr = a;
    b0.wr_cmd  = c;
    tick(1);
    b0.wr_en   = 1'b0;
  endtask

  // One send/busy handshake on the default instance; returns the launched frame.
  task automatic xmit0(output logic [15:0] a, output logic [7:0] c);
    int n;
    n = 0;
    while (!b0.tx_send && n < 50) begin
      tick(1);
      n++;
    end
    chk("xmit_wait", 32'(n < 50), 32'd1);
    a = b0.tx_addr;
    c = b0.tx_cmd;
    b0.tx_busy = 1'b1;
    tick(1);
    b0.tx_busy = 1'b0;
    tick(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [15:0] a;
    logic [7:0]  c;
    int          base;
    int          n;

    b0.wr_en = 1'b0; b0.wr_addr = '0; b0.wr_cmd = '0; b0.tx_busy = 1'b0;
    b1.wr_en = 1'b0; b1.wr_addr = '0; b1.wr_cmd = '0; b1.tx_busy = 1'b0;
`ifdef IR_TX_REPEAT_EN
    b0.wr_repeat = '0;
    b1.wr_repeat = '0;
`endif

    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_q_idle",  32'(q0), 32'd1);
    chk("rst_send",    32'(b0.tx_send), 32'd0);
    chk("rst_frames",  32'(fs0), 32'd0);
    chk("rst_level",   32'(b0.fifo_level), 32'd0);
    chk("rst_addr",    32'(b0.tx_addr), 32'd0);
    chk("rst_ovf_err", 32'({b0.wr_ovf, err0, b0.wr_full}), 32'd0);

    // Single frame, busy 3 cycles after send, held ~100 cycles
    push0(16'h00FF, 8'h45);
    chk("lat_level_n1", 32'(b0.fifo_level), 32'd1);
    chk("lat_send_n1",  32'(b0.tx_send), 32'd0);
    tick(1);
    chk("lat_send_n2",  32'(b0.tx_send), 32'd1);
    chk("lat_addr",     32'(b0.tx_addr), 32'h00FF);
    chk("lat_cmd",      32'(b0.tx_cmd), 32'h45);
    chk("lat_level_n2", 32'(b0.fifo_level), 32'd0);
    tick(2);
    chk("send_hold", 32'(b0.tx_send), 32'd1);
    tick(1);
    b0.tx_busy = 1'b1;
    tick(1);
    chk("send_drop", 32'(b0.tx_send), 32'd0);
    chk("frames_during_busy", 32'(fs0), 32'd0);
    tick(99);
    b0.tx_busy = 1'b0;
    tick(1);
    chk("frames_one", 32'(fs0), 32'd1);
    chk("idle_after_one", 32'(q0), 32'd1);
    chk("addr_stable", 32'(b0.tx_addr), 32'h00FF);

    // Overflow: one frame in flight with busy stuck, then nine pushes
    b0.tx_busy = 1'b1;
    push0(16'hAAAA, 8'h01);
    tick(3);
    base = ovf_cnt;
    for (int i = 0; i < 9; i++) push0(16'h1000 + 16'(i), 8'(i));
    tick(2);
    chk("ovf_level", 32'(b0.fifo_level), 32'd8);
    chk("ovf_full",  32'(b0.wr_full), 32'd1);
    chk("ovf_pulses", 32'(ovf_cnt - base), 32'd1);
    b0.tx_busy = 1'b0;
    tick(1);
    chk("frames_two", 32'(fs0), 32'd2);
    for (int i = 0; i < 8; i++) begin
      xmit0(a, c);
      chk($sformatf("drain_addr%0d", i), 32'(a), 32'h1000 + 32'(i));
      chk($sformatf("drain_cmd%0d", i),  32'(c), 32'(i));
    end
    tick(3);
    chk("drain_idle",   32'(q0), 32'd1);
    chk("drain_send",   32'(b0.tx_send), 32'd0);
    chk("drain_frames", 32'(fs0), 32'd10);

    // Ack timeout: first entry abandoned, second launched next
    push0(16'h0BAD, 8'h11);
    push0(16'h0C0D, 8'h22);
    n = 0;
    while (!b0.tx_send && n < 20) begin
      tick(1);
      n++;
    end
    chk("to_launch", 32'(b0.tx_send), 32'd1);
    n = 0;
    while (b0.tx_send && n < 1100) begin
      n++;
      tick(1);
    end
    chk("to_send_len", 32'(n), 32'd1000);
    chk("to_err_pulse", 32'(err0), 32'd1);
    tick(1);
    chk("to_err_clear", 32'(err0), 32'd0);
    chk("to_next_send", 32'(b0.tx_send), 32'd1);
    chk("to_next_addr", 32'(b0.tx_addr), 32'h0C0D);
    chk("to_frames",    32'(fs0), 32'd10);
    b0.tx_busy = 1'b1;
    tick(1);
    b0.tx_busy = 1'b0;
    tick(1);
    chk("to_next_done", 32'(fs0), 32'd11);

    // Inter-frame gap on the GAP_CYCLES=50 instance
    b1.wr_en = 1'b1; b1.wr_addr = 16'h2001; b1.wr_cmd = 8'h31;
    tick(1);
    b1.wr_addr = 16'h2002; b1.wr_cmd = 8'h32;
    tick(1);
    b1.wr_en = 1'b0;
    n = 0;
    while (!b1.tx_send && n < 20) begin
      tick(1);
      n++;
    end
    chk("gap_first_addr", 32'(b1.tx_addr), 32'h2001);
    b1.tx_busy = 1'b1;
    tick(1);
    b1.tx_busy = 1'b0;
    tick(1);
    n = 0;
    while (!b1.tx_send && n < 200) begin
      tick(1);
      n++;
    end
    chk("gap_len",         32'(n), 32'd51);
    chk("gap_second_addr", 32'(b1.tx_addr), 32'h2002);
    b1.tx_busy = 1'b1;
    tick(1);
    b1.tx_busy = 1'b0;
    tick(60);
    chk("gap_frames", 32'(fs1), 32'd2);
    chk("gap_idle",   32'(q1), 32'd1);

    // Reset with the default instance in S_BUSY (3 queued) and the gap instance in S_REQ
    b1.wr_en = 1'b1; b1.wr_addr = 16'h3003; b1.wr_cmd = 8'h33;
    tick(1);
    b1.wr_en = 1'b0;
    b0.tx_busy = 1'b1;
    for (int i = 0; i < 4; i++) push0(16'h4000 + 16'(i), 8'h40);
    tick(3);
    chk("pre_rst_level", 32'(b0.fifo_level), 32'd3);
    chk("pre_rst_send1", 32'(b1.tx_send), 32'd1);
    rst = 1'b1;
    tick(1);
    chk("rst_mid_send",   32'(b0.tx_send), 32'd0);
    chk("rst_mid_send1",  32'(b1.tx_send), 32'd0);
    chk("rst_mid_level",  32'(b0.fifo_level), 32'd0);
    chk("rst_mid_frames", 32'(fs0), 32'd0);
    chk("rst_mid_idle",   32'(q0), 32'd1);
    chk("rst_mid_addr",   32'(b0.tx_addr), 32'd0);
    rst = 1'b0;
    b0.tx_busy = 1'b0;
    tick(3);
    chk("post_rst_send", 32'(b0.tx_send), 32'd0);
    chk("post_rst_idle", 32'(q0), 32'd1);

`ifdef IR_TX_REPEAT_EN
    b0.wr_repeat = 4'd2;
    push0(16'h1234, 8'h56);
    b0.wr_repeat = 4'd0;
    for (int i = 0; i < 3; i++) begin
      xmit0(a, c);
      chk($sformatf("rep_addr%0d", i), 32'(a), 32'h1234);
      chk($sformatf("rep_cmd%0d", i),  32'(c), 32'h56);
      chk($sformatf("rep_level%0d", i), 32'(b0.fifo_level), 32'd0);
    end
    tick(2);
    chk("rep_send_done", 32'(b0.tx_send), 32'd0);
    chk("rep_frames",    32'(fs0), 32'd3);
    chk("rep_idle",      32'(q0), 32'd1);
`else
    push0(16'h1234, 8'h56);
    xmit0(a, c);
    chk("once_addr", 32'(a), 32'h1234);
    tick(3);
    chk("once_send_done", 32'(b0.tx_send), 32'd0);
    chk("once_frames",    32'(fs0), 32'd1);
    chk("once_idle",      32'(q0), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
